// File: rtl/data_decode_pipe.sv
// Read-side ECC stage for the synchronous FIFO. It corrects single-bit errors in a
// 38-bit Hamming word and keeps saturating error counters plus the first error syndrome.
module data_decode_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [37:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_sec,
    output logic             out_unc,
    input  logic             err_clr,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] unc_cnt,
    output logic             err_sticky,
    output logic [5:0]       first_syn
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             v1_q, v1_d;
    logic [37:0]      w1_q, w1_d;
    logic [5:0]       s1_q, s1_d;
    logic             v2_q, v2_d;
    logic [31:0]      data2_q, data2_d;
    logic             sec2_q, sec2_d;
    logic             unc2_q, unc2_d;
    logic [5:0]       syn2_q, syn2_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0] unc_cnt_q, unc_cnt_d;
    logic             sticky_q, sticky_d;
    logic [5:0]       first_syn_q, first_syn_d;

    logic             adv1, adv2;
    logic [5:0]       syn_in;
    logic [37:0]      fixed;
    logic [31:0]      dec_data;
    logic             dec_sec, dec_unc;
    logic             xfer, ev_sec, ev_unc;
    logic [CNT_W-1:0] sec_base, unc_base;
    logic             sticky_base;

    // Syndrome bit k covers every Hamming position (index+1) that has bit k set.
    always_comb begin
        syn_in = '0;
        for (int i = 0; i < 38; i++) begin
            for (int k = 0; k < 6; k++) begin
                if (((i + 1) & (1 << k)) != 0) begin
                    syn_in[k] = syn_in[k] ^ in_data[i];
                end
            end
        end
    end

    always_comb begin
        fixed   = w1_q;
        dec_sec = 1'b0;
        dec_unc = 1'b0;
        if (s1_q != 6'd0) begin
            if (s1_q <= 6'd38) begin
                fixed[s1_q - 6'd1] = ~w1_q[s1_q - 6'd1];
                dec_sec            = 1'b1;
            end else begin
                dec_unc = 1'b1;
            end
        end
        dec_data = {fixed[37:32], fixed[30:16], fixed[14:8], fixed[6:4], fixed[2]};
    end

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        v1_d    = v1_q;
        w1_d    = w1_q;
        s1_d    = s1_q;
        v2_d    = v2_q;
        data2_d = data2_q;
        sec2_d  = sec2_q;
        unc2_d  = unc2_q;
        syn2_d  = syn2_q;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                w1_d = in_data;
                s1_d = syn_in;
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                data2_d = dec_data;
                sec2_d  = dec_sec;
                unc2_d  = dec_unc;
                syn2_d  = s1_q;
            end
        end
    end

    // A clear and a same-cycle error event combine: clear first, then apply the event.
    always_comb begin
        xfer        = v2_q && out_ready;
        ev_sec      = xfer && sec2_q;
        ev_unc      = xfer && unc2_q;
        sec_base    = err_clr ? '0 : sec_cnt_q;
        unc_base    = err_clr ? '0 : unc_cnt_q;
        sticky_base = err_clr ? 1'b0 : sticky_q;
        sec_cnt_d   = sec_base;
        unc_cnt_d   = unc_base;
        sticky_d    = sticky_base || ev_sec || ev_unc;
        first_syn_d = err_clr ? 6'd0 : first_syn_q;
        if (ev_sec && sec_base != CNT_MAX) begin
            sec_cnt_d = sec_base + 1'b1;
        end
        if (ev_unc && unc_base != CNT_MAX) begin
            unc_cnt_d = unc_base + 1'b1;
        end
        if ((ev_sec || ev_unc) && !sticky_base) begin
            first_syn_d = syn2_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            w1_q        <= '0;
            s1_q        <= '0;
            v2_q        <= 1'b0;
            data2_q     <= '0;
            sec2_q      <= 1'b0;
            unc2_q      <= 1'b0;
            syn2_q      <= '0;
            sec_cnt_q   <= '0;
            unc_cnt_q   <= '0;
            sticky_q    <= 1'b0;
            first_syn_q <= '0;
        end else begin
            v1_q        <= v1_d;
            w1_q        <= w1_d;
            s1_q        <= s1_d;
            v2_q        <= v2_d;
            data2_q     <= data2_d;
            sec2_q      <= sec2_d;
            unc2_q      <= unc2_d;
            syn2_q      <= syn2_d;
            sec_cnt_q   <= sec_cnt_d;
            unc_cnt_q   <= unc_cnt_d;
            sticky_q    <= sticky_d;
            first_syn_q <= first_syn_d;
        end
    end

    assign out_valid  = v2_q;
    assign out_data   = data2_q;
    assign out_sec    = sec2_q;
    assign out_unc    = unc2_q;
    assign sec_cnt    = sec_cnt_q;
    assign unc_cnt    = unc_cnt_q;
    assign err_sticky = sticky_q;
    assign first_syn  = first_syn_q;

endmodule
